// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer cluster.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN_MULT,
    RUN_DIV,
    WRITE,
    DONE,
    EXC_DIV0,
    EXC_TO
  } muldiv_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 40;

  // High/Low source mux follows the unit that produced the result.
  function automatic logic hilo_for_op(input logic op);
    return (op == OP_DIV) ? SEL_DIV : SEL_MULT;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit / Mult-Div cluster handshake bundle for muldiv_sequencer.
// Optional abort input present when MULDIV_SEQ_ABORT_EN is defined.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] divisor;
  logic             mult_stop;
  logic             div_stop;
  logic             div_zero;
`ifdef MULDIV_SEQ_ABORT_EN
  logic             abort;
`endif
  logic             mult_start;
  logic             div_start;
  logic             hilo_sel;
  logic             high_we;
  logic             low_we;
  logic             busy;
  logic             done;
  logic             div0_exc;
  logic             timeout_exc;

  // Control unit side.
  modport master (
    output start, op, divisor, mult_stop, div_stop, div_zero,
`ifdef MULDIV_SEQ_ABORT_EN
    output abort,
`endif
    input  mult_start, div_start, hilo_sel, high_we, low_we,
    input  busy, done, div0_exc, timeout_exc
  );

  // Sequencer side.
  modport slave (
    input  start, op, divisor, mult_stop, div_stop, div_zero,
`ifdef MULDIV_SEQ_ABORT_EN
    input  abort,
`endif
    output mult_start, div_start, hilo_sel, high_we, low_we,
    output busy, done, div0_exc, timeout_exc
  );
endinterface

// File: rtl/muldiv_run_counter.sv
// Run-cycle counter with clear/enable and a registered terminal-count flag
// that is high while the count equals TIMEOUT_CYCLES-1.
module muldiv_run_counter
  import muldiv_pkg::*;
#(
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term_q, term_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    term_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the Mult/Div units for MULT/DIV: launch, wait for stop, write
// High/Low, report done or exceptions. Optional abort: MULDIV_SEQ_ABORT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  muldiv_state_t state_q, state_d;
  logic          op_q, op_d;
  logic          hilo_q, hilo_d;
  logic          mult_start_q, mult_start_d;
  logic          div_start_q, div_start_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div0_q, div0_d;
  logic          to_q, to_d;
  logic          cnt_clr, cnt_en, cnt_term;
  logic          abort_w;
  logic [WIDTH-1:0] divisor_w;

  assign divisor_w = bus.divisor;

`ifdef MULDIV_SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  muldiv_run_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_run_counter (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_o (cnt_term)
  );

  // Next state, then registered outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hilo_d  = hilo_q;
    cnt_clr = (state_q == LAUNCH);
    cnt_en  = (state_q == RUN_MULT) || (state_q == RUN_DIV);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          if ((bus.op == OP_DIV) && (divisor_w == '0)) begin
            state_d = EXC_DIV0;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (abort_w)              state_d = IDLE;
        else if (op_q == OP_DIV)  state_d = RUN_DIV;
        else                      state_d = RUN_MULT;
      end
      RUN_MULT: begin
        if (abort_w)            state_d = IDLE;
        else if (bus.mult_stop) state_d = WRITE;
        else if (cnt_term)      state_d = EXC_TO;
      end
      RUN_DIV: begin
        if (abort_w)           state_d = IDLE;
        else if (bus.div_zero) state_d = EXC_DIV0;
        else if (bus.div_stop) state_d = WRITE;
        else if (cnt_term)     state_d = EXC_TO;
      end
      WRITE:    state_d = DONE;
      DONE:     state_d = IDLE;
      EXC_DIV0: state_d = IDLE;
      EXC_TO:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d == LAUNCH) begin
      hilo_d = hilo_for_op(op_d);
    end

    mult_start_d = (state_d == LAUNCH) && (op_d == OP_MULT);
    div_start_d  = (state_d == LAUNCH) && (op_d == OP_DIV);
    we_d         = (state_d == WRITE);
    done_d       = (state_d == DONE);
    div0_d       = (state_d == EXC_DIV0);
    to_d         = (state_d == EXC_TO);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_MULT;
      hilo_q       <= SEL_DIV;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div0_q       <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      hilo_q       <= hilo_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div0_q       <= div0_d;
      to_q         <= to_d;
    end
  end

  assign bus.mult_start  = mult_start_q;
  assign bus.div_start   = div_start_q;
  assign bus.hilo_sel    = hilo_q;
  assign bus.high_we     = we_q;
  assign bus.low_we      = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div0_exc    = div0_q;
  assign bus.timeout_exc = to_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed sequences push expected
// output events (kind, cycle, hilo_sel); a forked monitor pops and compares.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam logic [6:0] E_MS = 7'b1000000;
  localparam logic [6:0] E_DS = 7'b0100000;
  localparam logic [6:0] E_WR = 7'b0011000;
  localparam logic [6:0] E_DN = 7'b0000100;
  localparam logic [6:0] E_D0 = 7'b0000010;
  localparam logic [6:0] E_TO = 7'b0000001;

  typedef struct {
    logic [6:0] vec;
    int         cyc;
    bit         chk_hilo;
    logic       hilo;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] obs_vec();
    return {bus.mult_start, bus.div_start, bus.high_we, bus.low_we,
            bus.done, bus.div0_exc, bus.timeout_exc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input logic [6:0] vec, input int at, input bit chk, input logic hilo);
    exp_t e;
    e.vec = vec; e.cyc = at; e.chk_hilo = chk; e.hilo = hilo;
    exp_q.push_back(e);
  endtask

  // Compares every output pulse against the oldest expected event.
  task automatic monitor();
    logic [6:0] o;
    exp_t       e;
    forever begin
      @(negedge clk);
      o = obs_vec();
      if (!rst && (o != 7'd0)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %b at cycle %0d, want none", o, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((o !== e.vec) || (cyc != e.cyc) || (e.chk_hilo && (bus.hilo_sel !== e.hilo))) begin
            n_err++;
            $display("FAIL event: got %b@%0d hilo=%b, want %b@%0d hilo=%b",
                     o, cyc, bus.hilo_sel, e.vec, e.cyc, e.hilo);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issues a one-cycle start; c is the cycle in which start was driven.
  task automatic issue(input logic op, input logic [31:0] dv, output int c);
    c           = cyc;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.divisor = dv;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int c;
    cyc = 0; n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.divisor = '0;
    bus.mult_stop = 1'b0; bus.div_stop = 1'b0; bus.div_zero = 1'b0;
`ifdef MULDIV_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    fork
      monitor();
    join_none

    ticks(2);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_pulses", 32'(obs_vec()), 0);
    check("reset_hilo", 32'(bus.hilo_sel), 0);
    rst = 1'b0;
    ticks(2);

    // MULT with zero divisor, stop after 5 run cycles; stray div_stop ignored.
    issue(OP_MULT, 32'h0, c);
    expect_ev(E_MS, c + 1, 1'b0, 1'b0);
    expect_ev(E_WR, c + 7, 1'b1, SEL_MULT);
    expect_ev(E_DN, c + 8, 1'b1, SEL_MULT);
    check("mult_busy_c1", 32'(bus.busy), 1);
    ticks(2); bus.div_stop = 1'b1;
    tick();   bus.div_stop = 1'b0;
    ticks(2); bus.mult_stop = 1'b1;
    tick();   bus.mult_stop = 1'b0;
    tick();
    check("mult_busy_c8", 32'(bus.busy), 1);
    tick();
    check("mult_busy_c9", 32'(bus.busy), 0);
    ticks(2);

    // DIV by zero: immediate exception, one busy cycle.
    issue(OP_DIV, 32'h0, c);
    expect_ev(E_D0, c + 1, 1'b0, 1'b0);
    check("div0_busy_c1", 32'(bus.busy), 1);
    tick();
    check("div0_busy_c2", 32'(bus.busy), 0);
    ticks(2);

    // Normal DIV: hilo_sel must switch back to Div results.
    issue(OP_DIV, 32'd12, c);
    expect_ev(E_DS, c + 1, 1'b0, 1'b0);
    expect_ev(E_WR, c + 5, 1'b1, SEL_DIV);
    expect_ev(E_DN, c + 6, 1'b1, SEL_DIV);
    ticks(3); bus.div_stop = 1'b1;
    tick();   bus.div_stop = 1'b0;
    ticks(4);

    // div_zero and div_stop together: zero wins.
    issue(OP_DIV, 32'd9, c);
    expect_ev(E_DS, c + 1, 1'b0, 1'b0);
    expect_ev(E_D0, c + 4, 1'b0, 1'b0);
    ticks(2); bus.div_zero = 1'b1; bus.div_stop = 1'b1;
    tick();   bus.div_zero = 1'b0; bus.div_stop = 1'b0;
    ticks(3);

    // DIV that never stops: timeout 41 cycles after LAUNCH; mult_stop ignored.
    issue(OP_DIV, 32'd7, c);
    expect_ev(E_DS, c + 1, 1'b0, 1'b0);
    expect_ev(E_TO, c + 42, 1'b0, 1'b0);
    ticks(4); bus.mult_stop = 1'b1;
    tick();   bus.mult_stop = 1'b0;
    ticks(36);
    check("to_busy_c42", 32'(bus.busy), 1);
    tick();
    check("to_busy_c43", 32'(bus.busy), 0);
    ticks(2);

    // div_stop on the timeout limit cycle wins; a start while busy is ignored.
    issue(OP_DIV, 32'd3, c);
    expect_ev(E_DS, c + 1, 1'b0, 1'b0);
    expect_ev(E_WR, c + 42, 1'b1, SEL_DIV);
    expect_ev(E_DN, c + 43, 1'b1, SEL_DIV);
    ticks(8);
    bus.start = 1'b1; bus.op = OP_MULT; bus.divisor = 32'd5;
    tick();
    bus.start = 1'b0;
    ticks(31); bus.div_stop = 1'b1;
    tick();    bus.div_stop = 1'b0;
    ticks(4);

`ifdef MULDIV_SEQ_ABORT_EN
    // Abort in the third RUN_MULT cycle, coinciding with mult_stop.
    issue(OP_MULT, 32'h0, c);
    expect_ev(E_MS, c + 1, 1'b0, 1'b0);
    ticks(3); bus.abort = 1'b1; bus.mult_stop = 1'b1;
    tick();   bus.abort = 1'b0; bus.mult_stop = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    ticks(3);
`endif

    // Asynchronous reset in RUN_DIV: outputs clear at once, no write afterwards.
    issue(OP_DIV, 32'd5, c);
    expect_ev(E_DS, c + 1, 1'b0, 1'b0);
    ticks(4);
    check("prereset_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy), 0);
    check("midreset_pulses", 32'(obs_vec()), 0);
    check("midreset_hilo", 32'(bus.hilo_sel), 0);
    bus.div_stop = 1'b1;
    tick();
    bus.div_stop = 1'b0;
    tick();
    rst = 1'b0;
    ticks(5);
    check("postreset_busy", 32'(bus.busy), 0);

    ticks(2);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
